cmac_tx_sim_sink: RTL and testbench

//   Synthesizable consumer for the shell's simulated CMAC TX stream (m_axis_cmac_tx_sim_*), one per CMAC port.

---
 rtl/cmac_tx_sim_sink.sv | 142 ++++++++++++++
 tb/tb_cmac_tx_sim_sink.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmac_tx_sim_sink.sv
// Consumer for the simulated CMAC TX stream: LFSR back-pressure, per-packet framing checks and statistics.
// Optional packet signature is built only when CMAC_SIM_SINK_SIG_EN is defined.
module cmac_tx_sim_sink #(
  parameter int          DATA_W      = 512,
  parameter int          MIN_PKT_LEN = 64,
  parameter int          MAX_PKT_LEN = 1518,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                cmac_clk,
  input  logic                cmac_rst,
  input  logic                s_axis_tvalid,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tuser_err,
  output logic                s_axis_tready,
  input  logic [3:0]          throttle_lvl,
  input  logic                stats_clr,
  output logic                pkt_done,
  output logic [15:0]         last_pkt_len,
  output logic [31:0]         last_pkt_sig,
  output logic [31:0]         pkt_cnt,
  output logic [47:0]         byte_cnt,
  output logic [15:0]         runt_cnt,
  output logic [15:0]         giant_cnt,
  output logic [15:0]         keep_err_cnt,
  output logic [15:0]         usr_err_cnt
);
  localparam int          KEEP_W = DATA_W / 8;
  localparam int          CNT_W  = $clog2(KEEP_W + 1);
  localparam logic [15:0] MIN_L  = 16'(MIN_PKT_LEN);
  localparam logic [15:0] MAX_L  = 16'(MAX_PKT_LEN);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;

  logic [15:0]       lfsr;
  logic [15:0]       len_acc, len_new;
  logic [16:0]       len_sum;
  logic [CNT_W-1:0]  beat_bytes;
  logic [KEEP_W-1:0] keep_inc;
  logic              keep_bad, keep_viol, accept, done;

  assign accept   = s_axis_tvalid && s_axis_tready;
  assign done     = accept && s_axis_tlast;
  assign keep_inc = s_axis_tkeep + KEEP_W'(1);

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_W; i++) beat_bytes = beat_bytes + CNT_W'(s_axis_tkeep[i]);
  end

  // Length saturates rather than wrapping so absurd packets still read as giant.
  assign len_sum = {1'b0, len_acc} + 17'(beat_bytes);
  assign len_new = len_sum[16] ? 16'hFFFF : len_sum[15:0];

  // Last beat: non-zero and LSB-contiguous; other beats: all bytes enabled.
  assign keep_viol = s_axis_tlast ? ((s_axis_tkeep == '0) || ((s_axis_tkeep & keep_inc) != '0))
                                  : (s_axis_tkeep != '1);

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = s_axis_tlast ? IDLE : ACTIVE;
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic en);
    return (en && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction

  always_ff @(posedge cmac_clk) begin
    if (cmac_rst) begin
      lfsr          <= LFSR_SEED;
      s_axis_tready <= 1'b0;
      state         <= IDLE;
      len_acc       <= '0;
      keep_bad      <= 1'b0;
      pkt_done      <= 1'b0;
      last_pkt_len  <= '0;
      pkt_cnt       <= '0;
      byte_cnt      <= '0;
      runt_cnt      <= '0;
      giant_cnt     <= '0;
      keep_err_cnt  <= '0;
      usr_err_cnt   <= '0;
    end else begin
      lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      s_axis_tready <= !(lfsr[3:0] < throttle_lvl);
      state         <= state_nxt;
      pkt_done      <= done;
      if (accept) begin
        len_acc  <= s_axis_tlast ? 16'd0 : len_new;
        keep_bad <= s_axis_tlast ? 1'b0 : (keep_bad | keep_viol);
      end
      if (stats_clr) begin
        last_pkt_len <= '0;
        pkt_cnt      <= '0;
        byte_cnt     <= '0;
        runt_cnt     <= '0;
        giant_cnt    <= '0;
        keep_err_cnt <= '0;
        usr_err_cnt  <= '0;
      end else if (done) begin
        last_pkt_len <= len_new;
        pkt_cnt      <= pkt_cnt + 32'd1;
        byte_cnt     <= byte_cnt + 48'(len_new);
        runt_cnt     <= sat_inc(runt_cnt, len_new < MIN_L);
        giant_cnt    <= sat_inc(giant_cnt, len_new > MAX_L);
        keep_err_cnt <= sat_inc(keep_err_cnt, keep_bad | keep_viol);
        usr_err_cnt  <= sat_inc(usr_err_cnt, s_axis_tuser_err);
      end
    end
  end

`ifdef CMAC_SIM_SINK_SIG_EN
  logic [31:0] sig_acc, fold, sig_new;

  // Disabled bytes contribute zero; byte i lands in lane i%4 of the folded word.
  always_comb begin
    fold = '0;
    for (int i = 0; i < KEEP_W; i++)
      if (s_axis_tkeep[i]) fold[(i % 4) * 8 +: 8] = fold[(i % 4) * 8 +: 8] ^ s_axis_tdata[i * 8 +: 8];
  end

  assign sig_new = {sig_acc[30:0], sig_acc[31]} ^ fold;

  always_ff @(posedge cmac_clk) begin
    if (cmac_rst) begin
      sig_acc      <= '0;
      last_pkt_sig <= '0;
    end else begin
      if (accept) sig_acc <= s_axis_tlast ? 32'd0 : sig_new;
      if (stats_clr) last_pkt_sig <= '0;
      else if (done) last_pkt_sig <= sig_new;
    end
  end
`else
  logic unused_data;
  assign unused_data  = ^s_axis_tdata;
  assign last_pkt_sig = 32'h0;
`endif

endmodule

// File: tb/tb_cmac_tx_sim_sink.sv
// Bench for cmac_tx_sim_sink: framing table, stats_clr/reset corners, randomized throttled traffic.
module tb_cmac_tx_sim_sink;
  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst;
  logic              tvalid, tlast, tuser, tready, stats_clr, pkt_done;
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [3:0]        throttle;
  logic [15:0]       last_len, runt_cnt, giant_cnt, keep_cnt, usr_cnt;
  logic [31:0]       last_sig, pkt_cnt;
  logic [47:0]       byte_cnt;

  always #5 clk = ~clk;

  cmac_tx_sim_sink dut (
    .cmac_clk(clk), .cmac_rst(rst),
    .s_axis_tvalid(tvalid), .s_axis_tdata(tdata), .s_axis_tkeep(tkeep),
    .s_axis_tlast(tlast), .s_axis_tuser_err(tuser), .s_axis_tready(tready),
    .throttle_lvl(throttle), .stats_clr(stats_clr), .pkt_done(pkt_done),
    .last_pkt_len(last_len), .last_pkt_sig(last_sig), .pkt_cnt(pkt_cnt),
    .byte_cnt(byte_cnt), .runt_cnt(runt_cnt), .giant_cnt(giant_cnt),
    .keep_err_cnt(keep_cnt), .usr_err_cnt(usr_cnt)
  );

  int nvec = 0, nerr = 0;
  int cyc = 0, low = 0;
  bit measuring = 0;
  logic [31:0] model_sig;

  always @(negedge clk) if (measuring) begin
    cyc++;
    if (!tready) low++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fold_of(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k);
    logic [31:0] f = '0;
    for (int i = 0; i < KEEP_W; i++) if (k[i]) f[(i % 4) * 8 +: 8] ^= d[i * 8 +: 8];
    return f;
  endfunction

  task automatic send_beat(input logic [63:0] keep, input logic last, input logic usr);
    logic [DATA_W-1:0] d;
    int n = 0;
    for (int w = 0; w < DATA_W / 32; w++) d[w * 32 +: 32] = $urandom;
    @(negedge clk);
    tvalid = 1'b1; tdata = d; tkeep = keep; tlast = last; tuser = usr;
    while (!tready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!tready) begin
      nvec++; nerr++;
      $display("FAIL ready_timeout: got tready=0 after %0d cycles, expected 1", n);
    end
    model_sig = {model_sig[30:0], model_sig[31]} ^ fold_of(d, keep);
    @(posedge clk);
  endtask

  task automatic send_pkt(input int nfull, input logic [63:0] last_keep, input logic usr, input int bad_mid);
    model_sig = '0;
    for (int i = 0; i < nfull; i++) send_beat((i == bad_mid) ? 64'hFFFF_FFFF_FFFF_FFFE : ALL1, 1'b0, 1'b0);
    send_beat(last_keep, 1'b1, usr);
  endtask

  task automatic idle();
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic chk_sig(input string name);
`ifdef CMAC_SIM_SINK_SIG_EN
    chk(name, last_sig, model_sig);
`else
    chk(name, last_sig, 32'h0);
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tready"}, tready, 0);
    chk({tag, "_pkt_done"}, pkt_done, 0);
    chk({tag, "_len"}, last_len, 0);
    chk({tag, "_sig"}, last_sig, 0);
    chk({tag, "_pkt_cnt"}, pkt_cnt, 0);
    chk({tag, "_byte_cnt"}, byte_cnt, 0);
    chk({tag, "_runt"}, runt_cnt, 0);
    chk({tag, "_giant"}, giant_cnt, 0);
    chk({tag, "_keep"}, keep_cnt, 0);
    chk({tag, "_usr"}, usr_cnt, 0);
  endtask

  typedef struct {
    int          nfull;
    logic [63:0] last_keep;
    logic        usr;
    int          bad_mid;
    int          len;
    bit          runt, giant, kerr;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int e_pkt = 0, e_runt = 0, e_giant = 0, e_keep = 0, e_usr = 0, e_len = 0;
    longint e_bytes = 0;

    tbl[0]  = '{0,  ALL1,                   1'b0, -1, 64,   0, 0, 0};
    tbl[1]  = '{23, 64'h3FFF_FFFF_FFFF,     1'b0, -1, 1518, 0, 0, 0};
    tbl[2]  = '{23, 64'h7FFF_FFFF_FFFF,     1'b0, -1, 1519, 0, 1, 0};
    tbl[3]  = '{0,  64'h0FFF_FFFF_FFFF_FFFF, 1'b1, -1, 60,   1, 0, 0};
    tbl[4]  = '{2,  ALL1,                   1'b0, 1,  191,  0, 0, 1};
    tbl[5]  = '{2,  ALL1,                   1'b0, -1, 192,  0, 0, 0};
    tbl[6]  = '{1,  64'h0,                  1'b0, -1, 64,   0, 0, 1};
    tbl[7]  = '{1,  64'h5,                  1'b0, -1, 66,   0, 0, 1};
    tbl[8]  = '{0,  64'h1,                  1'b1, -1, 1,    1, 0, 0};
    tbl[9]  = '{0,  64'h0,                  1'b0, -1, 0,    1, 0, 1};
    tbl[10] = '{0,  64'hFF00,               1'b0, -1, 8,    1, 0, 1};
    tbl[11] = '{1,  ALL1,                   1'b1, -1, 128,  0, 0, 0};

    rst = 1'b1; tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; tuser = 1'b0;
    throttle = 4'd0; stats_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    foreach (tbl[i]) begin
      send_pkt(tbl[i].nfull, tbl[i].last_keep, tbl[i].usr, tbl[i].bad_mid);
      idle();
      e_pkt++; e_bytes += tbl[i].len;
      e_runt += tbl[i].runt; e_giant += tbl[i].giant; e_keep += tbl[i].kerr; e_usr += tbl[i].usr;
      chk($sformatf("v%0d_pkt_done", i), pkt_done, 1);
      chk($sformatf("v%0d_len", i), last_len, tbl[i].len);
      chk($sformatf("v%0d_pkt_cnt", i), pkt_cnt, e_pkt);
      chk($sformatf("v%0d_byte_cnt", i), byte_cnt, e_bytes);
      chk($sformatf("v%0d_runt", i), runt_cnt, e_runt);
      chk($sformatf("v%0d_giant", i), giant_cnt, e_giant);
      chk($sformatf("v%0d_keep", i), keep_cnt, e_keep);
      chk($sformatf("v%0d_usr", i), usr_cnt, e_usr);
      chk_sig($sformatf("v%0d_sig", i));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse_end", i), pkt_done, 0);
    end

    // stats_clr on its own
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("clr_pkt_cnt", pkt_cnt, 0);
    chk("clr_byte_cnt", byte_cnt, 0);
    chk("clr_runt", runt_cnt, 0);
    chk("clr_keep", keep_cnt, 0);
    chk("clr_len", last_len, 0);

    // stats_clr coincident with tlast acceptance: the clear wins
    @(negedge clk);
    tvalid = 1'b1; tkeep = ALL1; tlast = 1'b1; tuser = 1'b1; stats_clr = 1'b1;
    chk("coinc_tready", tready, 1);
    @(posedge clk);
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; stats_clr = 1'b0;
    chk("coinc_pkt_cnt", pkt_cnt, 0);
    chk("coinc_byte_cnt", byte_cnt, 0);
    chk("coinc_usr", usr_cnt, 0);
    chk("coinc_len", last_len, 0);

    // one counted packet so the reset below has something to clear
    send_pkt(0, ALL1, 1'b0, -1);
    idle();
    chk("pre_rst_pkt_cnt", pkt_cnt, 1);

    // reset mid-packet, then a clean 128B packet must not inherit the partial one
    send_beat(ALL1, 1'b0, 1'b0);
    send_beat(ALL1, 1'b0, 1'b0);
    @(negedge clk);
    tvalid = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midrst");
    rst = 1'b0;
    send_pkt(1, ALL1, 1'b0, -1);
    idle();
    chk("post_rst_pkt_cnt", pkt_cnt, 1);
    chk("post_rst_len", last_len, 128);
    chk("post_rst_byte_cnt", byte_cnt, 128);
    chk("post_rst_keep", keep_cnt, 0);
    chk("post_rst_runt", runt_cnt, 0);

    // randomized throttled traffic against an arithmetic model
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0; throttle = 4'd8;
    e_pkt = 0; e_bytes = 0; e_runt = 0; e_giant = 0; e_usr = 0;
    measuring = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      int len, nfull, lastb;
      logic usr;
      logic [63:0] lk;
      len   = $urandom_range(1, 1600);
      nfull = (len - 1) / 64;
      lastb = len - 64 * nfull;
      lk    = (lastb == 64) ? ALL1 : ((64'd1 << lastb) - 64'd1);
      usr   = 1'($urandom_range(0, 1));
      e_pkt++; e_bytes += len; e_len = len;
      if (len < 64) e_runt++;
      if (len > 1518) e_giant++;
      if (usr) e_usr++;
      send_pkt(nfull, lk, usr, -1);
    end
    idle();
    measuring = 1'b0;
    chk("rnd_pkt_cnt", pkt_cnt, e_pkt);
    chk("rnd_byte_cnt", byte_cnt, e_bytes);
    chk("rnd_runt", runt_cnt, e_runt);
    chk("rnd_giant", giant_cnt, e_giant);
    chk("rnd_usr", usr_cnt, e_usr);
    chk("rnd_keep", keep_cnt, 0);
    chk("rnd_last_len", last_len, e_len);
    chk_sig("rnd_sig");
    chk("rnd_tready_low_pct_35_65", ((low * 100 / cyc) >= 35) && ((low * 100 / cyc) <= 65), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
